// File: rtl/fwd_source_pipe_pkg.sv
// Shared types for the operand-forwarding producer pipeline.
// XZR doubles as the "nothing to forward" destination tag.
package fwd_source_pipe_pkg;

  localparam logic [4:0] XZR = 5'd31;
  localparam int FWD_W = 64;

  typedef struct packed {
    logic [4:0]       rd;
    logic             we;
    logic             pending;
    logic [FWD_W-1:0] value;
  } fwd_entry_t;

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } ldst_t;

endpackage

// File: rtl/fwd_source_pipe_stage_reg.sv
// One forwarding entry register: advance, bubble-load, or in-place
// value patch when an outstanding load resolves.
module fwd_stage_reg
  import fwd_source_pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              bubble,
  input  logic              patch,
  input  logic [4:0]        in_rd,
  input  logic              in_we,
  input  logic              in_pend,
  input  logic [DATA_W-1:0] in_value,
  input  logic [DATA_W-1:0] patch_value,
  output logic [4:0]        rd,
  output logic              we,
  output logic              pending,
  output logic [DATA_W-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd      <= XZR;
      we      <= 1'b0;
      pending <= 1'b0;
      value   <= '0;
    end else if (patch) begin
      pending <= 1'b0;
      value   <= patch_value;
    end else if (en) begin
      if (bubble) begin
        rd      <= XZR;
        we      <= 1'b0;
        pending <= 1'b0;
        value   <= '0;
      end else begin
        rd      <= in_rd;
        we      <= in_we;
        pending <= in_pend;
        value   <= in_value;
      end
    end
  end

endmodule

// File: rtl/fwd_source_pipe.sv
// EX/MEM and MEM/WB forwarding source with a load-wait sequencer
// that freezes the front of the pipe until load data returns.
module fwd_source_pipe
  import fwd_source_pipe_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              flush,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic [4:0]        ExeRegIn,
  output logic [DATA_W-1:0] ExeValueIn,
  output logic [4:0]        MemRegIn,
  output logic [DATA_W-1:0] MemValueIn,
  output logic              hold_pipe,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  ldst_t          state;
  logic [CW-1:0]  cnt;
  logic           err_q;
  logic           run;
  logic           wait_st;
  logic           cap;
  logic           timeout;
  logic           a_patch;
  logic [DATA_W-1:0] a_patch_value;

  logic [4:0]        a_rd, b_rd;
  logic              a_we, b_we;
  logic              a_pend, b_pend;
  logic [DATA_W-1:0] a_value, b_value;

  assign run     = (state == RUN);
  assign wait_st = (state == LOAD_WAIT);
  assign cap     = ex_valid && !flush;
  assign timeout = wait_st && !mem_ready
                && (cnt == CW'(MEM_TIMEOUT - 1));
  assign a_patch = wait_st && (mem_ready || timeout);
  assign a_patch_value = mem_ready ? mem_load_data : '0;

  fwd_stage_reg #(.DATA_W(DATA_W)) u_stage_a (
    .clk         (clk),
    .reset       (reset),
    .en          (run),
    .bubble      (!cap),
    .patch       (a_patch),
    .in_rd       (ex_rd),
    .in_we       (ex_reg_write),
    .in_pend     (ex_mem_read),
    .in_value    (ex_result),
    .patch_value (a_patch_value),
    .rd          (a_rd),
    .we          (a_we),
    .pending     (a_pend),
    .value       (a_value)
  );

  fwd_stage_reg #(.DATA_W(DATA_W)) u_stage_b (
    .clk         (clk),
    .reset       (reset),
    .en          (run),
    .bubble      (1'b0),
    .patch       (1'b0),
    .in_rd       (a_rd),
    .in_we       (a_we),
    .in_pend     (a_pend),
    .in_value    (a_value),
    .patch_value ('0),
    .rd          (b_rd),
    .we          (b_we),
    .pending     (b_pend),
    .value       (b_value)
  );

  // mem_ready beats the timeout when both land in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (1'b1)
        run: begin
          if (cap && ex_mem_read) begin
            state <= LOAD_WAIT;
            cnt   <= '0;
          end
        end
        wait_st: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (timeout) begin
            state <= RUN;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign ExeRegIn   = (a_we && !a_pend) ? a_rd : XZR;
  assign ExeValueIn = a_value;
  assign MemRegIn   = (b_we && !b_pend) ? b_rd : XZR;
  assign MemValueIn = b_value;
  assign hold_pipe  = wait_st && !mem_ready;
  assign mem_busy   = wait_st;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_fwd_source_pipe.sv
// Directed scoreboard bench for fwd_source_pipe (MEM_TIMEOUT = 4).
// Stimulus queues expected outputs; a monitor pops and compares.
module tb_fwd_source_pipe;

  logic        clk;
  logic        reset;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result;
  logic        flush, mem_ready;
  logic [63:0] mem_load_data;
  logic [4:0]  ExeRegIn, MemRegIn;
  logic [63:0] ExeValueIn, MemValueIn;
  logic        hold_pipe, mem_busy, mem_err;

  fwd_source_pipe #(.DATA_W(64), .MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .ex_result     (ex_result),
    .flush         (flush),
    .mem_ready     (mem_ready),
    .mem_load_data (mem_load_data),
    .ExeRegIn      (ExeRegIn),
    .ExeValueIn    (ExeValueIn),
    .MemRegIn      (MemRegIn),
    .MemValueIn    (MemValueIn),
    .hold_pipe     (hold_pipe),
    .mem_busy      (mem_busy),
    .mem_err       (mem_err)
  );

  typedef struct {
    string       name;
    logic [4:0]  er;
    logic [63:0] ev;
    logic [4:0]  mr;
    logic [63:0] mv;
    logic        h, b, e;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  bit done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(
    input logic rst, input logic v, input logic rw,
    input logic mr, input logic [4:0] rd,
    input logic [63:0] res, input logic fl,
    input logic rdy, input logic [63:0] dat,
    input string nm, input logic [4:0] er,
    input logic [63:0] ev, input logic [4:0] mreg,
    input logic [63:0] mv, input logic h,
    input logic b, input logic e);
    exp_t x;
    @(negedge clk);
    reset = rst; ex_valid = v; ex_reg_write = rw;
    ex_mem_read = mr; ex_rd = rd; ex_result = res;
    flush = fl; mem_ready = rdy; mem_load_data = dat;
    x.name = nm; x.er = er; x.ev = ev; x.mr = mreg;
    x.mv = mv; x.h = h; x.b = b; x.e = e;
    sb.push_back(x);
  endtask

  // Monitor: outputs settle after the negedge drive
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (ExeRegIn === x.er && ExeValueIn === x.ev &&
            MemRegIn === x.mr && MemValueIn === x.mv &&
            hold_pipe === x.h && mem_busy === x.b &&
            mem_err === x.e)
          passed++;
        else
          $display("FAIL %s: got er=%0d ev=%h mr=%0d mv=%h h=%b b=%b e=%b want er=%0d ev=%h mr=%0d mv=%h h=%b b=%b e=%b",
            x.name, ExeRegIn, ExeValueIn, MemRegIn, MemValueIn,
            hold_pipe, mem_busy, mem_err,
            x.er, x.ev, x.mr, x.mv, x.h, x.b, x.e);
      end
    end
  end

  initial begin
    #20000;
    if (!done) begin
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
    end
  end

  initial begin
    reset = 1'b1; ex_valid = 0; ex_reg_write = 0;
    ex_mem_read = 0; ex_rd = 0; ex_result = 0;
    flush = 0; mem_ready = 0; mem_load_data = 0;
    //   rst v rw mr rd res fl rdy dat | name er ev mr mv h b e
    cyc(1,0,0,0,0,0,0,0,0, "reset", 31,0,31,0,0,0,0);
    cyc(0,1,1,0,3,64'h11,0,0,0, "idle", 31,0,31,0,0,0,0);
    cyc(0,1,1,0,4,64'h22,0,0,0, "alu1", 3,64'h11,31,0,0,0,0);
    cyc(0,1,1,0,7,64'h77,1,0,0, "alu2", 4,64'h22,3,64'h11,0,0,0);
    cyc(0,1,1,1,5,64'h100,0,0,0, "flush", 31,0,4,64'h22,0,0,0);
    cyc(0,1,1,0,9,64'h99,1,0,0, "ldw1", 31,64'h100,31,0,1,1,0);
    cyc(0,1,1,0,9,64'h99,1,0,0, "ldw2", 31,64'h100,31,0,1,1,0);
    cyc(0,1,1,0,9,64'h99,0,1,64'hDEAD, "ldrdy", 31,64'h100,31,0,0,1,0);
    cyc(0,0,0,0,0,0,0,0,0, "ldfwd", 5,64'hDEAD,31,0,0,0,0);
    cyc(0,1,1,1,6,64'h200,0,0,0, "ldadv", 31,0,5,64'hDEAD,0,0,0);
    for (int i = 0; i < 3; i++)
      cyc(0,0,0,0,0,0,0,0,0, "racew", 31,64'h200,31,0,1,1,0);
    cyc(0,0,0,0,0,0,0,1,64'hBEEF, "race", 31,64'h200,31,0,0,1,0);
    cyc(0,0,0,0,0,0,0,0,0, "racefwd", 6,64'hBEEF,31,0,0,0,0);
    cyc(0,1,1,1,8,64'h300,0,0,0, "toadv", 31,0,6,64'hBEEF,0,0,0);
    for (int i = 0; i < 4; i++)
      cyc(0,0,0,0,0,0,0,0,0, "tow", 31,64'h300,31,0,1,1,0);
    cyc(0,0,0,0,0,0,0,0,0, "toerr", 8,0,31,0,0,0,1);
    cyc(0,1,1,1,31,64'h400,0,0,0, "x31ld", 31,0,8,0,0,0,1);
    cyc(0,0,0,0,0,0,0,0,0, "x31w", 31,64'h400,31,0,1,1,1);
    cyc(0,0,0,0,0,0,0,1,64'h55, "x31rdy", 31,64'h400,31,0,0,1,1);
    cyc(0,0,0,0,0,0,0,0,0, "x31a", 31,64'h55,31,0,0,0,1);
    cyc(0,1,1,1,10,64'h500,0,0,0, "x31b", 31,0,31,64'h55,0,0,1);
    cyc(0,0,0,0,0,0,0,0,0, "prerst", 31,64'h500,31,0,1,1,1);
    cyc(1,0,0,0,0,0,0,0,0, "rstmid", 31,0,31,0,0,0,0);
    cyc(0,1,1,0,12,64'hAB,0,0,0, "rst2", 31,0,31,0,0,0,0);
    cyc(0,0,0,0,0,0,0,0,0, "postrst", 12,64'hAB,31,0,0,0,0);
    @(negedge clk);
    #5;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending want 0", sb.size());
    done = 1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fwd_source_pipe.md
Name: fwd_source_pipe

Overview:
- Producer side of the operand-forwarding interface: owns the EX/MEM (stage A) and MEM/WB (stage B) destination/result registers.
- Drives ExeRegIn/ExeValueIn/MemRegIn/MemValueIn to the decode-stage forwarding mux.
- Sequences variable-latency loads and freezes the pipeline while load data is outstanding.
- Uses 5'd31 (XZR) as the "nothing to forward" encoding, so consumers see a safe zero on any match.

Parameters:
- DATA_W, 64, datapath width.
- MEM_TIMEOUT, 255, max LOAD_WAIT cycles before abandoning a load.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_result  in  DATA_W  EX ALU result (load address for loads; unused as value).
- flush  in  1  branch taken; kill the EX instruction being captured.
- mem_ready  in  1  data memory returns load data this cycle.
- mem_load_data  in  DATA_W  load data, valid when mem_ready.
- ExeRegIn  out  5  stage A forwardable destination (31 = none).
- ExeValueIn  out  DATA_W  stage A value.
- MemRegIn  out  5  stage B forwardable destination (31 = none).
- MemValueIn  out  DATA_W  stage B value.
- hold_pipe  out  1  freeze IF/ID/EX registers this cycle.
- mem_busy  out  1  a load is outstanding (state LOAD_WAIT).
- mem_err  out  1  sticky: a load timed out.

Behaviour:
- Reset (async, immediate):
  - State RUN; A and B cleared (rd = 31, we = 0, pending = 0, value = 0); timeout counter = 0.
  - All outputs: ExeRegIn = 31, MemRegIn = 31, values = 0, hold_pipe = 0, mem_busy = 0, mem_err = 0.
- Capture qualifier: cap = ex_valid && !flush. A bubble is rd = 31, we = 0, load = 0, value = 0.
- State RUN, every edge:
  - B <= A (rd, we, value).
  - A <= cap ? {ex_rd, ex_reg_write, ex_mem_read, ex_result} : bubble.
  - A.pending = cap && ex_mem_read.
  - If the new A is pending: go to LOAD_WAIT and clear the counter.
- State LOAD_WAIT:
  - hold_pipe = !mem_ready (combinational); A, B and the EX inputs are not captured.
  - On mem_ready: A.value <= mem_load_data, A.pending <= 0, go to RUN, hold_pipe = 0 that cycle.
  - Pipeline advance resumes on the following edge. Latency is one LOAD_WAIT cycle minimum.
  - Otherwise the counter increments. When counter == MEM_TIMEOUT-1 and !mem_ready: A.value <= 0, A.pending <= 0, mem_err <= 1 (sticky until reset), go to RUN.
  - mem_ready and the timeout in the same cycle: mem_ready wins and mem_err is not set.
- Output encoding:
  - ExeRegIn = (A.we && !A.pending) ? A.rd : 31.
  - MemRegIn = B.we ? B.rd : 31.
  - Values come straight from the registers. A pending load is therefore never forwarded.
- mem_ready while in RUN: ignored.
- flush during LOAD_WAIT: ignored. The outstanding load is older and completes normally.
- flush in RUN affects only the capture into A; A and B always commit.
- Load with rd = 31 still waits for mem_ready but never forwards.
- Reset asserted mid-LOAD_WAIT aborts the load and returns to RUN with cleared registers.

Decomposition:
- Shared pipeline package:
  - constant XZR = 5'd31.
  - typedef fwd_entry_t {rd[4:0], we, pending, value[DATA_W-1:0]}.
  - enum ldst_t {RUN, LOAD_WAIT}.
- One natural sub-module, fwd_stage_reg: one entry register with async reset, enable, bubble-load and value-patch inputs; instantiated twice (stage A and stage B).
- FSM and timeout counter stay in the top.

Test Plan:
- Reset mid-LOAD_WAIT -> outputs immediately 31/0/0, hold_pipe = 0, mem_busy = 0; next capture proceeds normally.
- ALU chain: ex_rd = 3, result 0x11, then ex_rd = 4, result 0x22 -> edge 1: ExeRegIn = 3, ExeValueIn = 0x11; edge 2: ExeRegIn = 4, ExeValueIn = 0x22, MemRegIn = 3, MemValueIn = 0x11.
- Load to X5, mem_ready after 3 cycles with data 0xDEAD:
  - During the wait: ExeRegIn = 31, hold_pipe = 1, mem_busy = 1.
  - Ready cycle: hold_pipe = 0.
  - Next edge: ExeRegIn = 5, ExeValueIn = 0xDEAD.
- flush with ex_valid = 1, ex_rd = 7 -> stage A becomes a bubble: ExeRegIn = 31, ExeValueIn = 0; the prior A moves to B unchanged.
- Load never answered, MEM_TIMEOUT = 4 -> mem_err = 1 after 4 wait cycles, ExeValueIn = 0, back to RUN. mem_ready arriving in the 4th cycle instead -> mem_err stays 0.
- Load with ex_rd = 31, data 0x55 -> waits for mem_ready; ExeRegIn = 31 throughout; MemRegIn = 31 after it advances.
